multicycle_control: RTL and testbench

Main control FSM for the multicycle RISC-V datapath. It sequences each instruction through fetch, decode, execute, memory and write-back cycles. It drives the datapath mux selects and register write enables, and the 2-bit ALU operation class consumed by the ALU decoder. It handshakes with a single shared instruction/data memory port and counts retired instructions.

---
 rtl/multicycle_control.sv | 229 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control
//
// Main control FSM for the multicycle RISC-V datapath. Each instruction is
// sequenced through fetch, decode, execute, memory and write-back cycles.
// The FSM drives the datapath mux selects, the register write enables and the
// 2-bit ALU operation class. It handshakes with one shared instruction/data
// memory port and counts retired instructions.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   opcode     IR[6:0], valid from DECODE onward
//   mem_ready  memory completes the current request this cycle
//   alu_cond   branch condition from the ALU, valid in BRANCH
//   mem_req    memory request
//   mem_we     write strobe, qualified by mem_req
//   iord       address select: 0 = PC, 1 = ALUOut
//   ir_write   load IR and oldPC
//   pc_write   load PC
//   pc_src     0 = ALU result, 1 = ALUOut
//   reg_write  register file write
//   wb_sel     00 = ALUOut, 01 = MDR, 10 = PC (link)
//   alu_src_a  00 = PC, 01 = rs1, 10 = zero, 11 = oldPC
//   alu_src_b  00 = rs2, 01 = const 4, 10 = imm
//   alu_op     00 = add, 01 = R-type, 10 = I-type ALU, 11 = branch compare
//   halted     an illegal opcode was decoded
//   instret    retired-instruction count, wraps at 2^INSTRET_W

module multicycle_control #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic                 mem_ready,
  input  logic                 alu_cond,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 iord,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 halted,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    RST_IDLE,
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    EXEC_LUI,
    MEM_ADDR,
    MEM_RD,
    MEM_WR,
    WB_ALU,
    WB_MEM,
    BRANCH,
    JAL,
    HALT
  } state_e;

  state_e                 state_q, state_d;
  logic                   is_store_q, is_store_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic                   retire;

  // Next-state logic. The load/store direction is captured in DECODE so that
  // MEM_ADDR does not depend on the IR staying stable for another cycle.
  // retire flags every transition back to FETCH that completes an instruction.
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    retire     = 1'b0;
    case (state_q)
      RST_IDLE: state_d = FETCH;
      FETCH: begin
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        is_store_d = (opcode == OP_STORE);
        case (opcode)
          OP_R:               state_d = EXEC_R;
          OP_I:               state_d = EXEC_I;
          OP_LUI:             state_d = EXEC_LUI;
          OP_LOAD, OP_STORE:  state_d = MEM_ADDR;
          OP_BRANCH:          state_d = BRANCH;
          OP_JAL:             state_d = JAL;
          default:            state_d = HALT;
        endcase
      end
      EXEC_R, EXEC_I, EXEC_LUI: state_d = WB_ALU;
      MEM_ADDR: state_d = is_store_q ? MEM_WR : MEM_RD;
      MEM_RD: begin
        if (mem_ready) state_d = WB_MEM;
      end
      MEM_WR: begin
        if (mem_ready) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      WB_ALU, WB_MEM, BRANCH, JAL: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      HALT:    state_d = HALT;
      default: state_d = RST_IDLE;
    endcase
  end

  // Retired-instruction counter; natural modulo wrap of the adder.
  always_comb begin
    instret_d = instret_q;
    if (retire) instret_d = instret_q + INSTRET_W'(1);
  end

  // Output decode from the registered state. Only the FETCH strobes depend on
  // mem_ready and the BRANCH pc_write on alu_cond; everything else is Moore.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'b00;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_op    = 2'b00;
    halted    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        // Precompute oldPC + imm into ALUOut as the branch/jump target.
        alu_src_a = 2'b11;
        alu_src_b = 2'b10;
      end
      EXEC_R: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b00;
        alu_op    = 2'b01;
      end
      EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = 2'b10;
      end
      EXEC_LUI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
      end
      MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      WB_ALU: begin
        reg_write = 1'b1;
      end
      WB_MEM: begin
        reg_write = 1'b1;
        wb_sel    = 2'b01;
      end
      BRANCH: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b11;
        pc_src    = 1'b1;
        pc_write  = alu_cond;
      end
      JAL: begin
        // PC still holds oldPC+4 this cycle, so the link value is written
        // while the PC takes the jump target from ALUOut.
        pc_write  = 1'b1;
        pc_src    = 1'b1;
        reg_write = 1'b1;
        wb_sel    = 2'b10;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: ;
    endcase
  end

  assign instret = instret_q;

  // State, store flag and retire counter; reset abandons any instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_IDLE;
      is_store_q <= 1'b0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      instret_q  <= instret_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//
// Directed bench for multicycle_control (INSTRET_W = 4). A table of per-cycle
// {inputs, expected outputs} records walks a mix of instructions, then
// hand-written sequences cover asynchronous reset and counter wrap.

module tb_multicycle_control;

  localparam int IW = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  // Packed outputs: {mem_req, mem_we, iord, ir_write, pc_write, pc_src,
  //                  reg_write, wb_sel[1:0], alu_src_a[1:0], alu_src_b[1:0],
  //                  alu_op[1:0], halted}
  localparam logic [15:0] O_IDLE   = 16'h0000;
  localparam logic [15:0] O_FWAIT  = 16'h8008;
  localparam logic [15:0] O_FRDY   = 16'h9808;
  localparam logic [15:0] O_DEC    = 16'h0070;
  localparam logic [15:0] O_EXR    = 16'h0022;
  localparam logic [15:0] O_EXI    = 16'h0034;
  localparam logic [15:0] O_LUI    = 16'h0050;
  localparam logic [15:0] O_MADDR  = 16'h0030;
  localparam logic [15:0] O_MRD    = 16'hA000;
  localparam logic [15:0] O_MWR    = 16'hE000;
  localparam logic [15:0] O_WBALU  = 16'h0200;
  localparam logic [15:0] O_WBMEM  = 16'h0280;
  localparam logic [15:0] O_BRT    = 16'h0C26;
  localparam logic [15:0] O_BRN    = 16'h0426;
  localparam logic [15:0] O_JAL    = 16'h0F00;
  localparam logic [15:0] O_HALT   = 16'h0001;

  logic          clk;
  logic          rst_n;
  logic [6:0]    opcode;
  logic          mem_ready;
  logic          alu_cond;
  logic          mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write;
  logic [1:0]    wb_sel, alu_src_a, alu_src_b, alu_op;
  logic          halted;
  logic [IW-1:0] instret;
  logic [15:0]   outs;

  int compared;
  int mismatched;

  typedef struct {
    logic [6:0]    op;
    logic          rdy;
    logic          cond;
    logic [15:0]   exp;
    logic [IW-1:0] exp_ir;
  } vec_t;

  vec_t vecs[$];

  multicycle_control #(.INSTRET_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .alu_cond  (alu_cond),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .iord      (iord),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .reg_write (reg_write),
    .wb_sel    (wb_sel),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .halted    (halted),
    .instret   (instret)
  );

  assign outs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
                 wb_sel, alu_src_a, alu_src_b, alu_op, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives inputs at the falling edge and lets the decode settle.
  task automatic applyStimulus(input logic [6:0] op, input logic rdy, input logic cond);
    opcode    = op;
    mem_ready = rdy;
    alu_cond  = cond;
    #1;
  endtask

  // Compares the packed outputs and the retire counter.
  task automatic checkOutput(input string name, input logic [15:0] exp, input logic [IW-1:0] exp_ir);
    compared++;
    if (outs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s outputs: got %h expected %h", name, outs, exp);
    end
    compared++;
    if (instret !== exp_ir) begin
      mismatched++;
      $display("[TB] FAIL %s instret: got %0d expected %0d", name, instret, exp_ir);
    end
  endtask

  task automatic addVec(input logic [6:0] op, input logic rdy, input logic cond,
                        input logic [15:0] exp, input logic [IW-1:0] exp_ir);
    vec_t v;
    v.op = op; v.rdy = rdy; v.cond = cond; v.exp = exp; v.exp_ir = exp_ir;
    vecs.push_back(v);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    opcode     = '0;
    mem_ready  = 1'b0;
    alu_cond   = 1'b0;

    // Cycle-by-cycle table starting at the first cycle after reset release.
    addVec(OP_I,      0, 0, O_IDLE,  0);
    addVec(OP_I,      1, 0, O_FRDY,  0);
    addVec(OP_I,      1, 0, O_DEC,   0);
    addVec(OP_I,      1, 0, O_EXI,   0);
    addVec(OP_I,      1, 0, O_WBALU, 0);
    addVec(OP_R,      1, 0, O_FRDY,  1);
    addVec(OP_R,      1, 0, O_DEC,   1);
    addVec(OP_R,      1, 0, O_EXR,   1);
    addVec(OP_R,      1, 0, O_WBALU, 1);
    addVec(OP_LUI,    0, 0, O_FWAIT, 2);
    addVec(OP_LUI,    1, 0, O_FRDY,  2);
    addVec(OP_LUI,    1, 0, O_DEC,   2);
    addVec(OP_LUI,    1, 0, O_LUI,   2);
    addVec(OP_LUI,    1, 0, O_WBALU, 2);
    addVec(OP_STORE,  1, 0, O_FRDY,  3);
    addVec(OP_STORE,  1, 0, O_DEC,   3);
    addVec(OP_STORE,  1, 0, O_MADDR, 3);
    addVec(OP_STORE,  1, 0, O_MWR,   3);
    addVec(OP_LOAD,   1, 0, O_FRDY,  4);
    addVec(OP_LOAD,   1, 0, O_DEC,   4);
    addVec(OP_LOAD,   1, 0, O_MADDR, 4);
    addVec(OP_LOAD,   0, 0, O_MRD,   4);
    addVec(OP_LOAD,   0, 0, O_MRD,   4);
    addVec(OP_LOAD,   0, 0, O_MRD,   4);
    addVec(OP_LOAD,   1, 0, O_MRD,   4);
    addVec(OP_LOAD,   1, 0, O_WBMEM, 4);
    addVec(OP_BRANCH, 1, 1, O_FRDY,  5);
    addVec(OP_BRANCH, 1, 1, O_DEC,   5);
    addVec(OP_BRANCH, 1, 1, O_BRT,   5);
    addVec(OP_BRANCH, 1, 0, O_FRDY,  6);
    addVec(OP_BRANCH, 1, 0, O_DEC,   6);
    addVec(OP_BRANCH, 1, 0, O_BRN,   6);
    addVec(OP_JAL,    1, 0, O_FRDY,  7);
    addVec(OP_JAL,    1, 0, O_DEC,   7);
    addVec(OP_JAL,    1, 0, O_JAL,   7);
    addVec(OP_BAD,    1, 0, O_FRDY,  8);
    addVec(OP_BAD,    1, 0, O_DEC,   8);
    addVec(OP_BAD,    1, 0, O_HALT,  8);
    addVec(OP_BAD,    1, 1, O_HALT,  8);
    addVec(OP_R,      1, 1, O_HALT,  8);

    // Outputs while reset is held.
    @(negedge clk);
    applyStimulus(OP_R, 1, 1);
    checkOutput("in_reset", O_IDLE, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].rdy, vecs[i].cond);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp, vecs[i].exp_ir);
      @(negedge clk);
    end

    // Reset out of HALT clears halted and instret without a clock edge.
    applyStimulus(OP_BAD, 1, 0);
    checkOutput("halt_hold", O_HALT, 8);
    #2 rst_n = 1'b0;
    #1 checkOutput("halt_async_rst", O_IDLE, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(OP_R, 1, 0);
    checkOutput("rst1_idle", O_IDLE, 0);
    @(negedge clk);
    applyStimulus(OP_R, 1, 0); checkOutput("r_fetch", O_FRDY, 0);  @(negedge clk);
    applyStimulus(OP_R, 1, 0); checkOutput("r_dec", O_DEC, 0);     @(negedge clk);
    applyStimulus(OP_R, 1, 0); checkOutput("r_exec", O_EXR, 0);    @(negedge clk);
    applyStimulus(OP_R, 1, 0); checkOutput("r_wb", O_WBALU, 0);    @(negedge clk);

    // Store stalled in MEM_WR, then reset mid-cycle.
    applyStimulus(OP_STORE, 1, 0); checkOutput("st_fetch", O_FRDY, 1);  @(negedge clk);
    applyStimulus(OP_STORE, 1, 0); checkOutput("st_dec", O_DEC, 1);     @(negedge clk);
    applyStimulus(OP_STORE, 1, 0); checkOutput("st_addr", O_MADDR, 1);  @(negedge clk);
    applyStimulus(OP_STORE, 0, 0); checkOutput("st_wait1", O_MWR, 1);   @(negedge clk);
    applyStimulus(OP_STORE, 0, 0); checkOutput("st_wait2", O_MWR, 1);
    #2 rst_n = 1'b0;
    #1 checkOutput("st_async_rst", O_IDLE, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(OP_R, 0, 0); checkOutput("rst2_idle", O_IDLE, 0);    @(negedge clk);
    applyStimulus(OP_R, 0, 0); checkOutput("rst2_fetch", O_FWAIT, 0);  @(negedge clk);

    // Sixteen R-type instructions wrap the 4-bit counter.
    for (int n = 0; n < 16; n++) begin
      applyStimulus(OP_R, 1, 0);
      checkOutput($sformatf("wrap%0d_fetch", n), O_FRDY, IW'(n));
      @(negedge clk);
      applyStimulus(OP_R, 1, 0); @(negedge clk);
      applyStimulus(OP_R, 1, 0); @(negedge clk);
      applyStimulus(OP_R, 1, 0);
      checkOutput($sformatf("wrap%0d_wb", n), O_WBALU, IW'(n));
      @(negedge clk);
    end
    applyStimulus(OP_R, 0, 0);
    checkOutput("wrap_zero", O_FWAIT, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
